// File: rtl/axis_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_gen
// Brief    : AXI-Stream frame generator (length sweep, INC/LFSR payload, gap,
//            packet count, statistics). Optional RX checker: AXIS_PKT_GEN_CHK_EN
// Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_gen #(
   parameter int DATA_WIDTH = 64,
   parameter int LEN_W      = 14,
   parameter int CNT_W      = 32,
   parameter int GAP_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic [LEN_W-1:0]        cfg_min_len,
   input  logic [LEN_W-1:0]        cfg_max_len,
   input  logic                    cfg_len_mode,
   input  logic                    cfg_pld_mode,
   input  logic [CNT_W-1:0]        cfg_pkt_num,
   input  logic [GAP_W-1:0]        cfg_gap,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
   output logic                    m_axis_tlast,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic                    s_axis_tlast,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_W-1:0]        tx_pkt_cnt,
   output logic [47:0]             tx_byte_cnt,
   output logic [CNT_W-1:0]        rx_pkt_cnt,
   output logic [CNT_W-1:0]        rx_err_cnt,
   output logic                    rx_err
);

   localparam int               KEEP_W     = DATA_WIDTH / 8;
   localparam int               LANES      = DATA_WIDTH / 32;
   localparam logic [31:0]      LFSR_TAPS  = 32'h8020_0003;
   localparam logic [31:0]      LFSR_SEED  = 32'hFFFF_FFFF;
   localparam logic [LEN_W-1:0] BEAT_BYTES = LEN_W'(KEEP_W);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_SEND = 3'd2,
      S_GAP  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   function automatic logic [LEN_W-1:0] first_len(input logic [LEN_W-1:0] mn);
      return (mn == '0) ? LEN_W'(1) : mn;
   endfunction

   // Reaching max (or min > max) wraps back to the effective minimum.
   function automatic logic [LEN_W-1:0] next_len(input logic [LEN_W-1:0] cur,
                                                 input logic [LEN_W-1:0] mn,
                                                 input logic [LEN_W-1:0] mx,
                                                 input logic             sweep);
      if (!sweep || cur >= mx) return first_len(mn);
      return cur + LEN_W'(1);
   endfunction

   function automatic logic [KEEP_W-1:0] keep_for(input logic [LEN_W-1:0] rem);
      logic [KEEP_W-1:0] k;
      for (int i = 0; i < KEEP_W; i++) k[i] = (rem > LEN_W'(i));
      return k;
   endfunction

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] beat_data(input logic              lfsr_mode,
                                                       input logic [7:0]        p8,
                                                       input logic [7:0]        off,
                                                       input logic [31:0]       lfsr,
                                                       input logic [KEEP_W-1:0] keep);
      logic [DATA_WIDTH-1:0] lanes;
      logic [DATA_WIDTH-1:0] d;
      lanes = '0;
      d     = '0;
      for (int j = 0; j < LANES; j++) lanes[j*32 +: 32] = lfsr + 32'(j);
      for (int i = 0; i < KEEP_W; i++) begin
         if (keep[i]) d[i*8 +: 8] = lfsr_mode ? lanes[i*8 +: 8] : (p8 + off + 8'(i));
      end
      return d;
   endfunction

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  min_q, min_d;
   logic [LEN_W-1:0]  max_q, max_d;
   logic              len_mode_q, len_mode_d;
   logic              pld_mode_q, pld_mode_d;
   logic [CNT_W-1:0]  pkt_num_q, pkt_num_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic              first_q, first_d;
   logic              stop_q, stop_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  rem_q, rem_d;
   logic [7:0]        off_q, off_d;
   logic [7:0]        p8_q, p8_d;
   logic [31:0]       lfsr_q, lfsr_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0]  tx_pkt_cnt_q, tx_pkt_cnt_d;
   logic [47:0]       tx_byte_cnt_q, tx_byte_cnt_d;

   logic [LEN_W-1:0]  load_len;
   logic [CNT_W-1:0]  load_p;
   logic              last_beat;
   logic              pkt_reached;
   logic [KEEP_W-1:0] tx_keep;

   assign load_len    = first_q ? first_len(min_q) : next_len(len_q, min_q, max_q, len_mode_q);
   assign load_p      = first_q ? '0 : tx_pkt_cnt_q;
   assign last_beat   = (rem_q <= BEAT_BYTES);
   assign pkt_reached = (pkt_num_q != '0) && (tx_pkt_cnt_q + CNT_W'(1) == pkt_num_q);
   assign tx_keep     = keep_for(rem_q);

   always_comb begin
      state_d       = state_q;
      min_d         = min_q;
      max_d         = max_q;
      len_mode_d    = len_mode_q;
      pld_mode_d    = pld_mode_q;
      pkt_num_d     = pkt_num_q;
      gap_d         = gap_q;
      first_d       = first_q;
      stop_d        = stop_q;
      len_d         = len_q;
      rem_d         = rem_q;
      off_d         = off_q;
      p8_d          = p8_q;
      lfsr_d        = lfsr_q;
      gap_cnt_d     = gap_cnt_q;
      tx_pkt_cnt_d  = tx_pkt_cnt_q;
      tx_byte_cnt_d = tx_byte_cnt_q;

      if (stop && state_q != S_IDLE) stop_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               min_d      = cfg_min_len;
               max_d      = cfg_max_len;
               len_mode_d = cfg_len_mode;
               pld_mode_d = cfg_pld_mode;
               pkt_num_d  = cfg_pkt_num;
               gap_d      = cfg_gap;
               first_d    = 1'b1;
               stop_d     = 1'b0;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            len_d   = load_len;
            rem_d   = load_len;
            off_d   = 8'd0;
            p8_d    = load_p[7:0];
            lfsr_d  = LFSR_SEED ^ 32'(load_p);
            first_d = 1'b0;
            if (first_q) begin
               tx_pkt_cnt_d  = '0;
               tx_byte_cnt_d = '0;
            end
            state_d = S_SEND;
         end
         S_SEND: begin
            if (m_axis_tready) begin
               lfsr_d = lfsr_step(lfsr_q);
               off_d  = off_q + 8'(KEEP_W);
               if (last_beat) begin
                  tx_pkt_cnt_d  = tx_pkt_cnt_q + CNT_W'(1);
                  tx_byte_cnt_d = tx_byte_cnt_q + 48'(len_q);
                  if (stop_q || stop || pkt_reached) begin
                     state_d = S_DONE;
                  end else if (gap_q != '0) begin
                     gap_cnt_d = gap_q;
                     state_d   = S_GAP;
                  end else begin
                     state_d = S_LOAD;
                  end
               end else begin
                  rem_d = rem_q - BEAT_BYTES;
               end
            end
         end
         S_GAP: begin
            if (gap_cnt_q <= GAP_W'(1)) state_d = S_LOAD;
            else                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         min_q         <= '0;
         max_q         <= '0;
         len_mode_q    <= 1'b0;
         pld_mode_q    <= 1'b0;
         pkt_num_q     <= '0;
         gap_q         <= '0;
         first_q       <= 1'b0;
         stop_q        <= 1'b0;
         len_q         <= '0;
         rem_q         <= '0;
         off_q         <= '0;
         p8_q          <= '0;
         lfsr_q        <= '0;
         gap_cnt_q     <= '0;
         tx_pkt_cnt_q  <= '0;
         tx_byte_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         min_q         <= min_d;
         max_q         <= max_d;
         len_mode_q    <= len_mode_d;
         pld_mode_q    <= pld_mode_d;
         pkt_num_q     <= pkt_num_d;
         gap_q         <= gap_d;
         first_q       <= first_d;
         stop_q        <= stop_d;
         len_q         <= len_d;
         rem_q         <= rem_d;
         off_q         <= off_d;
         p8_q          <= p8_d;
         lfsr_q        <= lfsr_d;
         gap_cnt_q     <= gap_cnt_d;
         tx_pkt_cnt_q  <= tx_pkt_cnt_d;
         tx_byte_cnt_q <= tx_byte_cnt_d;
      end
   end

   // Beat outputs derive only from flops that move on a handshake, so they hold while stalled.
   assign m_axis_tvalid = (state_q == S_SEND);
   assign m_axis_tkeep  = m_axis_tvalid ? tx_keep : '0;
   assign m_axis_tlast  = m_axis_tvalid && last_beat;
   assign m_axis_tdata  = m_axis_tvalid ? beat_data(pld_mode_q, p8_q, off_q, lfsr_q, tx_keep) : '0;
   assign busy          = (state_q != S_IDLE);
   assign done          = (state_q == S_DONE);
   assign tx_pkt_cnt    = tx_pkt_cnt_q;
   assign tx_byte_cnt   = tx_byte_cnt_q;
   assign s_axis_tready = 1'b1;

`ifdef AXIS_PKT_GEN_CHK_EN
   function automatic logic [DATA_WIDTH-1:0] byte_mask(input logic [KEEP_W-1:0] keep);
      logic [DATA_WIDTH-1:0] m;
      for (int i = 0; i < KEEP_W; i++) m[i*8 +: 8] = {8{keep[i]}};
      return m;
   endfunction

   logic [LEN_W-1:0]  rx_len_q, rx_len_d;
   logic [LEN_W-1:0]  rx_rem_q, rx_rem_d;
   logic [7:0]        rx_off_q, rx_off_d;
   logic [CNT_W-1:0]  rx_p_q, rx_p_d;
   logic [31:0]       rx_lfsr_q, rx_lfsr_d;
   logic              rx_bad_q, rx_bad_d;
   logic [CNT_W-1:0]  rx_pkt_cnt_q, rx_pkt_cnt_d;
   logic [CNT_W-1:0]  rx_err_cnt_q, rx_err_cnt_d;
   logic              rx_err_q, rx_err_d;

   logic [KEEP_W-1:0]     exp_keep;
   logic                  exp_last;
   logic [DATA_WIDTH-1:0] exp_data;
   logic                  beat_bad;
   logic [LEN_W-1:0]      rx_next_len;
   logic [CNT_W-1:0]      rx_next_p;

   assign exp_keep    = keep_for(rx_rem_q);
   assign exp_last    = (rx_rem_q <= BEAT_BYTES);
   assign exp_data    = beat_data(pld_mode_q, rx_p_q[7:0], rx_off_q, rx_lfsr_q, exp_keep);
   assign beat_bad    = (s_axis_tkeep != exp_keep) || (s_axis_tlast != exp_last) ||
                        ((s_axis_tdata & byte_mask(exp_keep)) != exp_data);
   assign rx_next_len = next_len(rx_len_q, min_q, max_q, len_mode_q);
   assign rx_next_p   = rx_p_q + CNT_W'(1);

   always_comb begin
      rx_len_d     = rx_len_q;
      rx_rem_d     = rx_rem_q;
      rx_off_d     = rx_off_q;
      rx_p_d       = rx_p_q;
      rx_lfsr_d    = rx_lfsr_q;
      rx_bad_d     = rx_bad_q;
      rx_pkt_cnt_d = rx_pkt_cnt_q;
      rx_err_cnt_d = rx_err_cnt_q;
      rx_err_d     = rx_err_q;

      if (s_axis_tvalid) begin
         if (s_axis_tlast) begin
            rx_pkt_cnt_d = rx_pkt_cnt_q + CNT_W'(1);
            if (rx_bad_q || beat_bad) begin
               rx_err_cnt_d = rx_err_cnt_q + CNT_W'(1);
               rx_err_d     = 1'b1;
            end
            rx_len_d  = rx_next_len;
            rx_rem_d  = rx_next_len;
            rx_off_d  = 8'd0;
            rx_p_d    = rx_next_p;
            rx_lfsr_d = LFSR_SEED ^ 32'(rx_next_p);
            rx_bad_d  = 1'b0;
         end else begin
            rx_bad_d  = rx_bad_q || beat_bad;
            rx_lfsr_d = lfsr_step(rx_lfsr_q);
            rx_off_d  = rx_off_q + 8'(KEEP_W);
            // An overlong frame keeps expecting its final beat rather than underflowing.
            if (!exp_last) rx_rem_d = rx_rem_q - BEAT_BYTES;
         end
      end

      if (state_q == S_IDLE && start) begin
         rx_len_d  = first_len(cfg_min_len);
         rx_rem_d  = first_len(cfg_min_len);
         rx_off_d  = 8'd0;
         rx_p_d    = '0;
         rx_lfsr_d = LFSR_SEED;
         rx_bad_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_len_q     <= '0;
         rx_rem_q     <= '0;
         rx_off_q     <= '0;
         rx_p_q       <= '0;
         rx_lfsr_q    <= '0;
         rx_bad_q     <= 1'b0;
         rx_pkt_cnt_q <= '0;
         rx_err_cnt_q <= '0;
         rx_err_q     <= 1'b0;
      end else begin
         rx_len_q     <= rx_len_d;
         rx_rem_q     <= rx_rem_d;
         rx_off_q     <= rx_off_d;
         rx_p_q       <= rx_p_d;
         rx_lfsr_q    <= rx_lfsr_d;
         rx_bad_q     <= rx_bad_d;
         rx_pkt_cnt_q <= rx_pkt_cnt_d;
         rx_err_cnt_q <= rx_err_cnt_d;
         rx_err_q     <= rx_err_d;
      end
   end

   assign rx_pkt_cnt = rx_pkt_cnt_q;
   assign rx_err_cnt = rx_err_cnt_q;
   assign rx_err     = rx_err_q;
`else
   logic unused_rx;
   assign unused_rx  = ^{s_axis_tvalid, s_axis_tdata, s_axis_tkeep, s_axis_tlast};
   assign rx_pkt_cnt = '0;
   assign rx_err_cnt = '0;
   assign rx_err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_gen
// Brief    : Scoreboard bench for axis_pkt_gen (64-bit stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_gen;

   localparam int DW = 64;
   localparam int KW = 8;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
   } beat_t;

   logic          clk, rst, start, stop;
   logic [13:0]   cfg_min_len, cfg_max_len;
   logic          cfg_len_mode, cfg_pld_mode;
   logic [31:0]   cfg_pkt_num;
   logic [7:0]    cfg_gap;
   logic          m_tvalid, m_tready, m_tlast;
   logic [DW-1:0] m_tdata;
   logic [KW-1:0] m_tkeep;
   logic          s_tvalid, s_tready, s_tlast;
   logic [DW-1:0] s_tdata;
   logic [KW-1:0] s_tkeep;
   logic          busy, done, rx_err;
   logic [31:0]   tx_pkt_cnt, rx_pkt_cnt, rx_err_cnt;
   logic [47:0]   tx_byte_cnt;

   logic          loop_en = 1'b0;
   logic          rand_rdy = 1'b0;

   // Loopback corrupts byte 0 of the last beat of frame 2.
   assign s_tvalid = loop_en & m_tvalid & m_tready;
   assign s_tdata  = m_tdata ^ ((tx_pkt_cnt == 32'd2 && m_tlast) ? 64'hFF : 64'h0);
   assign s_tkeep  = m_tkeep;
   assign s_tlast  = m_tlast;

   axis_pkt_gen dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .cfg_min_len(cfg_min_len), .cfg_max_len(cfg_max_len),
      .cfg_len_mode(cfg_len_mode), .cfg_pld_mode(cfg_pld_mode),
      .cfg_pkt_num(cfg_pkt_num), .cfg_gap(cfg_gap),
      .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
      .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
      .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast),
      .busy(busy), .done(done), .tx_pkt_cnt(tx_pkt_cnt), .tx_byte_cnt(tx_byte_cnt),
      .rx_pkt_cnt(rx_pkt_cnt), .rx_err_cnt(rx_err_cnt), .rx_err(rx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion earlier");
      $fatal(1, "watchdog");
   end

   int        n_checks = 0;
   int        n_err    = 0;
   beat_t     exp_q[$];
   logic [7:0] lastk_q[$];
   bit        sb_en = 1'b1;
   int        done_cnt = 0, hs_cnt = 0, idle_run = 0, frames_in_run = 0, exp_idle = -1;
   bit        in_frame = 1'b0, stall_prev = 1'b0;
   logic [DW+KW:0] prev_beat;
   logic [31:0] first_lane0;
   beat_t     mon_b;

   logic [7:0] t2_keeps [5] = '{8'hFF, 8'h01, 8'h03, 8'hFF, 8'h01};

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lfsr_next(input logic [31:0] s);
      return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
   endfunction

   task automatic push_frame(input int len_in, input int p, input bit lfsr_mode);
      int          len, nb, kk;
      logic [31:0] s, lane;
      beat_t       b;
      len = (len_in == 0) ? 1 : len_in;
      s   = 32'hFFFF_FFFF ^ 32'(p);
      nb  = (len + KW - 1) / KW;
      for (int bi = 0; bi < nb; bi++) begin
         b.d = '0;
         b.k = '0;
         for (int i = 0; i < KW; i++) begin
            kk = bi * KW + i;
            if (kk < len) begin
               b.k[i] = 1'b1;
               lane   = s + 32'(i / 4);
               b.d[i*8 +: 8] = lfsr_mode ? lane[(i%4)*8 +: 8] : 8'(p + kk);
            end
         end
         b.l = (bi == nb - 1);
         exp_q.push_back(b);
         s = lfsr_next(s);
      end
   endtask

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (stall_prev)
         chk("stall_hold", {m_tvalid, m_tdata, m_tkeep, m_tlast}, {1'b1, prev_beat});
      stall_prev = m_tvalid && !m_tready;
      prev_beat  = {m_tdata, m_tkeep, m_tlast};
      if (!m_tvalid) begin
         idle_run++;
      end else if (m_tready) begin
         hs_cnt++;
         if (!in_frame) begin
            if (exp_idle >= 0 && frames_in_run > 0) chk("ifg_idle_cycles", idle_run, exp_idle);
            if (frames_in_run == 0) first_lane0 = m_tdata[31:0];
            in_frame = 1'b1;
         end
         if (sb_en) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL unexpected_beat: got beat %h, required no beat", {m_tdata, m_tkeep, m_tlast});
            end else begin
               mon_b = exp_q.pop_front();
               chk("beat", {m_tdata, m_tkeep, m_tlast}, mon_b);
            end
         end
         if (m_tlast) begin
            lastk_q.push_back(m_tkeep);
            frames_in_run++;
            in_frame = 1'b0;
            idle_run = 0;
         end
      end
   end

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic set_cfg(input int mn, input int mx, input bit lm, input bit pm,
                          input int num, input int gap);
      cfg_min_len  = 14'(mn);
      cfg_max_len  = 14'(mx);
      cfg_len_mode = lm;
      cfg_pld_mode = pm;
      cfg_pkt_num  = 32'(num);
      cfg_gap      = 8'(gap);
   endtask

   task automatic reset_mon(input int idle);
      frames_in_run = 0;
      in_frame      = 1'b0;
      idle_run      = 0;
      exp_idle      = idle;
      lastk_q.delete();
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int c0, input int budget);
      int n = 0;
      while (done_cnt == c0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, done_cnt != c0, 1);
   endtask

   task automatic wait_beats(input string name, input int target, input int budget);
      int n = 0;
      while (hs_cnt < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, hs_cnt >= target, 1);
   endtask

   function automatic logic [7:0] pop_lastk();
      if (lastk_q.size() == 0) return 8'hxx;
      return lastk_q.pop_front();
   endfunction

   int c0, base, vcnt;

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      set_cfg(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", m_tvalid, 0);
      chk("rst_tkeep", m_tkeep, 0);
      chk("rst_tlast", m_tlast, 0);
      chk("rst_s_tready", s_tready, 1);
      chk("rst_busy_done", {busy, done}, 0);
      chk("rst_tx_cnts", {tx_pkt_cnt, tx_byte_cnt}, 0);
      chk("rst_rx_cnts", {rx_pkt_cnt, rx_err_cnt, rx_err}, 0);
      rst = 1'b0;

      // Fixed length 60, 3 frames, gap 4, INC
      set_cfg(60, 60, 0, 0, 3, 4);
      reset_mon(5);
      for (int p = 0; p < 3; p++) push_frame(60, p, 1'b0);
      c0 = done_cnt;
      pulse_start();
      chk("t1_busy", busy, 1);
      wait_done("t1_done_seen", c0, 2000);
      repeat (10) @(negedge clk);
      chk("t1_done_once", done_cnt - c0, 1);
      chk("t1_tx_pkt_cnt", tx_pkt_cnt, 3);
      chk("t1_tx_byte_cnt", tx_byte_cnt, 180);
      for (int i = 0; i < 3; i++) chk("t1_last_keep", pop_lastk(), 8'h0F);
      chk("t1_queue_empty", exp_q.size(), 0);
      chk("t1_idle_busy", busy, 0);

      // Sweep 64..66, 5 frames, no gap
      set_cfg(64, 66, 1, 0, 5, 0);
      reset_mon(1);
      push_frame(64, 0, 1'b0); push_frame(65, 1, 1'b0); push_frame(66, 2, 1'b0);
      push_frame(64, 3, 1'b0); push_frame(65, 4, 1'b0);
      c0 = done_cnt;
      pulse_start();
      wait_done("t2_done_seen", c0, 2000);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 5; i++) chk("t2_last_keep", pop_lastk(), t2_keeps[i]);
      chk("t2_tx_byte_cnt", tx_byte_cnt, 324);
      chk("t2_queue_empty", exp_q.size(), 0);

      // LFSR payload under random back-pressure
      set_cfg(20, 20, 0, 1, 2, 1);
      reset_mon(2);
      push_frame(20, 0, 1'b1); push_frame(20, 1, 1'b1);
      c0 = done_cnt;
      rand_rdy = 1'b1;
      pulse_start();
      wait_done("t3_done_seen", c0, 2000);
      rand_rdy = 1'b0;
      repeat (5) @(negedge clk);
      chk("t3_first_lane0", first_lane0, 32'hFFFF_FFFF);
      chk("t3_tx_pkt_cnt", tx_pkt_cnt, 2);
      chk("t3_queue_empty", exp_q.size(), 0);

      // Continuous run, stop mid-frame 1
      set_cfg(40, 40, 0, 0, 0, 2);
      reset_mon(3);
      push_frame(40, 0, 1'b0); push_frame(40, 1, 1'b0);
      c0   = done_cnt;
      base = hs_cnt;
      pulse_start();
      wait_beats("t4_reach_mid_frame", base + 7, 500);
      @(posedge clk); #1 stop = 1'b1;
      @(posedge clk); #1 stop = 1'b0;
      wait_done("t4_done_seen", c0, 500);
      vcnt = 0;
      repeat (20) begin
         @(negedge clk);
         if (m_tvalid) vcnt++;
      end
      chk("t4_no_tvalid_after_done", vcnt, 0);
      chk("t4_tx_pkt_cnt", tx_pkt_cnt, 2);
      chk("t4_queue_empty", exp_q.size(), 0);

      // Reset in the middle of frame 1
      sb_en = 1'b0;
      set_cfg(60, 60, 0, 0, 3, 0);
      reset_mon(-1);
      base = hs_cnt;
      pulse_start();
      wait_beats("t5_reach_frame1", base + 11, 500);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1;
      chk("t5_tvalid_after_rst", m_tvalid, 0);
      chk("t5_tx_cnts_after_rst", {tx_pkt_cnt, tx_byte_cnt}, 0);
      chk("t5_busy_after_rst", busy, 0);
      rst = 1'b0;
      exp_q.delete();
      reset_mon(-1);
      sb_en = 1'b1;
      set_cfg(60, 60, 0, 0, 1, 0);
      push_frame(60, 0, 1'b0);
      c0 = done_cnt;
      pulse_start();
      wait_done("t5_restart_done", c0, 500);
      repeat (3) @(negedge clk);
      chk("t5_restart_cnts", {tx_pkt_cnt, tx_byte_cnt}, {32'd1, 48'd60});
      chk("t5_queue_empty", exp_q.size(), 0);

      // Loopback into the checker, frame 2 corrupted
      loop_en = 1'b1;
      set_cfg(60, 61, 1, 0, 4, 2);
      reset_mon(3);
      push_frame(60, 0, 1'b0); push_frame(61, 1, 1'b0);
      push_frame(60, 2, 1'b0); push_frame(61, 3, 1'b0);
      c0 = done_cnt;
      pulse_start();
      wait_done("t6_done_seen", c0, 2000);
      repeat (5) @(negedge clk);
      loop_en = 1'b0;
`ifdef AXIS_PKT_GEN_CHK_EN
      chk("t6_rx_stats", {rx_pkt_cnt, rx_err_cnt, rx_err}, {32'd4, 32'd1, 1'b1});
`else
      chk("t6_rx_stats", {rx_pkt_cnt, rx_err_cnt, rx_err}, {32'd0, 32'd0, 1'b0});
`endif
      chk("t6_tx_byte_cnt", tx_byte_cnt, 242);
      chk("t6_queue_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
